// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: first-word-fall-through byte FIFO between UART RX and TX
// with TX gating, flush, overflow accounting and saturating statistics.
module uart_echo_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 16,
  localparam int LVL_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              tx_en,
  input  logic              flush,
  input  logic              clear_stats,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [LVL_W-1:0]  high_water
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s, rd_plus1_s;
  logic [LVL_W-1:0]  level_r, level_nxt_s, high_water_r;
  logic [DATA_W-1:0] out_data_r, head_nxt_s;
  logic              full_r, empty_r;
  logic [CNT_W-1:0]  rx_count_r, tx_count_r, drop_count_r;
  logic              pop_s, push_s, drop_s;

  assign out_valid  = tx_en & ~empty_r;
  assign out_data   = out_data_r;
  assign level      = level_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign rx_count   = rx_count_r;
  assign tx_count   = tx_count_r;
  assign drop_count = drop_count_r;
  assign high_water = high_water_r;

  // Handshake decode, next pointers/level, and the next head byte.
  always_comb begin
    pop_s        = out_valid & out_ready & ~flush;
    push_s       = in_valid & (~full_r | pop_s) & ~flush;
    drop_s       = in_valid & ~push_s;
    rd_plus1_s   = rd_ptr_r + PTR_W'(1);
    level_nxt_s  = level_r;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    head_nxt_s   = out_data_r;
    if (flush) begin
      level_nxt_s  = {LVL_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      level_nxt_s  = level_r + LVL_W'(push_s) - LVL_W'(pop_s);
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_s);
    end
    // The head register must already hold the next front byte, so it is
    // loaded from the incoming byte when the FIFO is (or becomes) otherwise empty.
    if (flush) begin
      head_nxt_s = out_data_r;
    end else if (pop_s) begin
      if (level_r == LVL_W'(1)) begin
        head_nxt_s = push_s ? in_data : out_data_r;
      end else begin
        head_nxt_s = mem_r[rd_plus1_s];
      end
    end else if (push_s && empty_r) begin
      head_nxt_s = in_data;
    end else begin
      head_nxt_s = out_data_r;
    end
  end

  // Storage array; contents need no reset because the head register masks stale slots.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO control state, head register and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {LVL_W{1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      out_data_r   <= {DATA_W{1'b0}};
      rx_count_r   <= {CNT_W{1'b0}};
      tx_count_r   <= {CNT_W{1'b0}};
      drop_count_r <= {CNT_W{1'b0}};
      high_water_r <= {LVL_W{1'b0}};
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == LVL_W'(DEPTH));
      empty_r    <= (level_nxt_s == {LVL_W{1'b0}});
      out_data_r <= head_nxt_s;
      if (clear_stats) begin
        rx_count_r   <= {CNT_W{1'b0}};
        tx_count_r   <= {CNT_W{1'b0}};
        drop_count_r <= {CNT_W{1'b0}};
        high_water_r <= level_nxt_s;
      end else begin
        rx_count_r   <= sat_inc(rx_count_r, in_valid);
        tx_count_r   <= sat_inc(tx_count_r, pop_s);
        drop_count_r <= sat_inc(drop_count_r, drop_s);
        if (level_nxt_s > high_water_r) begin
          high_water_r <= level_nxt_s;
        end else begin
          high_water_r <= high_water_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard testbench for uart_echo_fifo: directed stimulus pushes expected
// bytes into a queue, a negedge monitor checks every byte handed to TX.
module tb_uart_echo_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          tx_en = 1'b0;
  logic          flush = 1'b0;
  logic          clear_stats = 1'b0;

  logic [DW-1:0] out_data, s_out_data;
  logic          out_valid, s_out_valid, full, s_full, empty, s_empty;
  logic [LW-1:0] level, s_level, high_water, s_high_water;
  logic [15:0]   rx_count, tx_count, drop_count;
  logic [3:0]    s_rx_count, s_tx_count, s_drop_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_echo_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tx_en(tx_en), .flush(flush), .clear_stats(clear_stats),
    .level(level), .full(full), .empty(empty),
    .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count),
    .high_water(high_water)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  uart_echo_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .tx_en(tx_en), .flush(flush), .clear_stats(clear_stats),
    .level(s_level), .full(s_full), .empty(s_empty),
    .rx_count(s_rx_count), .tx_count(s_tx_count), .drop_count(s_drop_count),
    .high_water(s_high_water)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever this condition holds.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic [DW-1:0] d,
                      input logic fl = 1'b0, input logic cs = 1'b0);
    in_valid = iv; in_data = d; flush = fl; clear_stats = cs;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    tx_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 60 && !(empty && exp_q.size() == 0); i++) step(1'b0, 8'h00);
    chk({name, "_drained"}, {31'd0, empty}, 32'd1);
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // 1: reset, with an in_valid strobe during reset that must be ignored
    tx_en = 1'b1; out_ready = 1'b1;
    do_reset();
    chk("rst_level", level, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_rx", rx_count, 32'd0);
    chk("rst_tx", tx_count, 32'd0);
    chk("rst_drop", drop_count, 32'd0);
    chk("rst_hw", high_water, 32'd0);

    // 2: echo one byte, one-cycle latency
    exp_q.push_back(8'h41);
    step(1'b1, 8'h41);
    chk("echo_valid", {31'd0, out_valid}, 32'd1);
    chk("echo_data", out_data, 32'h41);
    chk("echo_level", level, 32'd1);
    step(1'b0, 8'h00);
    chk("echo_tx", tx_count, 32'd1);
    chk("echo_empty", {31'd0, empty}, 32'd1);

    // 3: overflow with TX held off
    do_reset();
    tx_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(i));
      step(1'b1, 8'(i));
    end
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_level", level, DEPTH);
    chk("ovf_drop", drop_count, 32'd3);
    chk("ovf_rx", rx_count, DEPTH + 3);
    chk("ovf_hw", high_water, DEPTH);
    chk("ovf_gated", {31'd0, out_valid}, 32'd0);
    chk("ovf_head", out_data, 32'h00);
    drain("ovf");
    chk("ovf_tx", tx_count, DEPTH);

    // 4: push and pop together while full
    do_reset();
    tx_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      step(1'b1, 8'h10 + 8'(i));
    end
    tx_en = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'hAA);
    step(1'b1, 8'hAA);
    chk("fpp_level", level, DEPTH);
    chk("fpp_full", {31'd0, full}, 32'd1);
    chk("fpp_drop", drop_count, 32'd0);
    chk("fpp_head", out_data, 32'h11);
    drain("fpp");
    chk("fpp_tx", tx_count, DEPTH + 1);

    // 5: flush colliding with push and pop
    do_reset();
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h50 + 8'(i));
      step(1'b1, 8'h50 + 8'(i));
    end
    tx_en = 1'b1; out_ready = 1'b1;
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    exp_q.delete();
    chk("fl_level", level, 32'd0);
    chk("fl_empty", {31'd0, empty}, 32'd1);
    chk("fl_drop", drop_count, 32'd1);
    chk("fl_tx", tx_count, 32'd0);
    chk("fl_rx", rx_count, 32'd6);
    chk("fl_hw", high_water, 32'd5);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(8'h77);
    step(1'b1, 8'h77);
    chk("fl_post_data", out_data, 32'h77);
    step(1'b0, 8'h00);
    chk("fl_post_tx", tx_count, 32'd1);

    // 6: saturation on the 4-bit counters, then clear_stats
    do_reset();
    tx_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      step(1'b1, 8'h80 + 8'(i));
    end
    step(1'b0, 8'h00);
    chk("sat_rx", s_rx_count, 32'd15);
    chk("sat_tx", s_tx_count, 32'd15);
    chk("sat_drop", s_drop_count, 32'd0);
    chk("wide_rx", rx_count, 32'd20);
    chk("wide_tx", tx_count, 32'd20);
    chk("sat_hw", s_high_water, 32'd1);
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      step(1'b1, 8'hC0 + 8'(i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_rx", s_rx_count, 32'd0);
    chk("clr_tx", s_tx_count, 32'd0);
    chk("clr_drop", s_drop_count, 32'd0);
    chk("clr_hw", s_high_water, 32'd3);
    chk("clr_level", s_level, 32'd3);
    exp_q.push_back(8'hC3);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    chk("clr_ev_rx", rx_count, 32'd0);
    chk("clr_ev_hw", high_water, 32'd4);
    chk("clr_ev_level", level, 32'd4);
    drain("clr");
    chk("clr_tx_after", tx_count, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
